des_subkey_sequencer: RTL

Round-key sequencer directly downstream of the SPI key loader. Takes the sixteen 48-bit DES subkeys that the loader exposes in parallel and issues them one per round to the DES round engine over a valid/ack handshake. Encrypt order is subkey 00 to 15; decrypt order is 15 to 00. Runs entirely in the spi_clk domain.

---
 rtl/des_subkey_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/des_subkey_sequencer.sv
// Issues the sixteen DES subkeys one per round over a valid/ack handshake,
// ascending for encrypt and descending for decrypt.
module des_subkey_sequencer #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned KEY_W      = 48
) (
  input  logic             spi_clk,
  input  logic             n_reset,
  input  logic [KEY_W-1:0] key_in00,
  input  logic [KEY_W-1:0] key_in01,
  input  logic [KEY_W-1:0] key_in02,
  input  logic [KEY_W-1:0] key_in03,
  input  logic [KEY_W-1:0] key_in04,
  input  logic [KEY_W-1:0] key_in05,
  input  logic [KEY_W-1:0] key_in06,
  input  logic [KEY_W-1:0] key_in07,
  input  logic [KEY_W-1:0] key_in08,
  input  logic [KEY_W-1:0] key_in09,
  input  logic [KEY_W-1:0] key_in10,
  input  logic [KEY_W-1:0] key_in11,
  input  logic [KEY_W-1:0] key_in12,
  input  logic [KEY_W-1:0] key_in13,
  input  logic [KEY_W-1:0] key_in14,
  input  logic [KEY_W-1:0] key_in15,
  input  logic             key_ready,
  input  logic             start,
  input  logic             decrypt,
  input  logic             round_ack,
  input  logic             abort,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic [3:0]       round_num,
  output logic             key_valid,
  output logic             busy,
  output logic             done,
  output logic             start_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  state_t           state, state_n;
  logic             mode, mode_n;
  logic [3:0]       idx_n, num_n;
  logic [KEY_W-1:0] key_n;
  logic             valid_n, busy_n, done_n, err_n;
  logic [KEY_W-1:0] keys [NUM_ROUNDS];

  assign keys[0]  = key_in00;
  assign keys[1]  = key_in01;
  assign keys[2]  = key_in02;
  assign keys[3]  = key_in03;
  assign keys[4]  = key_in04;
  assign keys[5]  = key_in05;
  assign keys[6]  = key_in06;
  assign keys[7]  = key_in07;
  assign keys[8]  = key_in08;
  assign keys[9]  = key_in09;
  assign keys[10] = key_in10;
  assign keys[11] = key_in11;
  assign keys[12] = key_in12;
  assign keys[13] = key_in13;
  assign keys[14] = key_in14;
  assign keys[15] = key_in15;

  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    mode_n  = mode;
    idx_n   = round_idx;
    num_n   = round_num;
    key_n   = round_key;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && key_ready) begin
          state_n = ISSUE;
          mode_n  = decrypt;
          idx_n   = decrypt ? LAST : '0;
          num_n   = '0;
          key_n   = keys[idx_n];
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end else if (start) begin
          err_n = 1'b1;
        end
      end
      ISSUE: begin
        valid_n = 1'b1;
        busy_n  = 1'b1;
        // abort outranks key loss, which outranks ack; all three exits clear the outputs
        if (abort || !key_ready || (round_ack && round_num == LAST)) begin
          state_n = (abort || !key_ready) ? IDLE : DONE;
          err_n   = !abort && !key_ready;
          done_n  = !abort && key_ready;
          idx_n   = '0;
          num_n   = '0;
          key_n   = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
        end else if (round_ack) begin
          idx_n = mode ? round_idx - 4'd1 : round_idx + 4'd1;
          num_n = round_num + 4'd1;
          key_n = keys[idx_n];
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      mode      <= 1'b0;
      round_idx <= '0;
      round_num <= '0;
      round_key <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      mode      <= mode_n;
      round_idx <= idx_n;
      round_num <= num_n;
      round_key <= key_n;
      key_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
      start_err <= err_n;
    end
  end

endmodule
